// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory bus among N_REQ req/ack masters.
// Define BUS_ARB_LOCK_EN to let a locking master keep the bus across accesses.
module bus_arbiter #(
    parameter int unsigned N_REQ       = 3,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ-1:0]          lock,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      mem_r,
    output logic                      mem_w
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   own_q, own_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [3:0]         wcnt_q, wcnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               mem_r_q, mem_r_d;
    logic               mem_w_q, mem_w_d;

    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   cand;
    logic               found;

`ifndef BUS_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    // Scan starts just after the previous owner so nobody wins twice while others wait.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            cand = IDX_W'((int'(last_q) + i) % int'(N_REQ));
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
`ifdef BUS_ARB_LOCK_EN
        if (lock[last_q] && req[last_q]) begin
            winner = last_q;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        last_d      = last_q;
        wcnt_d      = wcnt_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_r_d     = mem_r_q;
        mem_w_d     = mem_w_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    own_d = winner;
                    for (int i = 0; i < int'(N_REQ); i++) begin
                        gnt_d[i] = (winner == IDX_W'(i));
                    end
                    mem_addr_d  = addr[int'(winner)*ADDR_W +: ADDR_W];
                    mem_wdata_d = wdata[int'(winner)*DATA_W +: DATA_W];
                    mem_r_d     = ~we[winner];
                    mem_w_d     = we[winner];
                    wcnt_d      = 4'(WAIT_CYCLES);
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    if (mem_r_q) begin
                        rdata_d = mem_rdata;
                    end
                    mem_r_d = 1'b0;
                    mem_w_d = 1'b0;
                    for (int i = 0; i < int'(N_REQ); i++) begin
                        ack_d[i] = (own_q == IDX_W'(i));
                    end
                    last_d  = own_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            own_q       <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            wcnt_q      <= '0;
            gnt_q       <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_r_q     <= 1'b0;
            mem_w_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            last_q      <= last_d;
            wcnt_q      <= wcnt_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_r_q     <= mem_r_d;
            mem_w_q     <= mem_w_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != StIdle);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_r     = mem_r_q;
    assign mem_w     = mem_w_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: scoreboarded accesses, rotation, reset abort and lock.
module tb_bus_arbiter;
    localparam int N_REQ       = 3;
    localparam int WAIT_CYCLES = 1;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [N_REQ-1:0]         req, we, lock;
    logic [N_REQ*ADDR_W-1:0]  addr;
    logic [N_REQ*DATA_W-1:0]  wdata;
    logic [N_REQ-1:0]         gnt, ack;
    logic [DATA_W-1:0]        rdata, mem_wdata, mem_rdata;
    logic                     busy, mem_r, mem_w;
    logic [ADDR_W-1:0]        mem_addr;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          model_last;
    logic [7:0]  model_rdata;

    typedef struct {
        int          own;
        logic        is_wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  rd;
    } txn_t;
    txn_t sb[$];

    always #5 clk = ~clk;

    // Memory returns a data pattern derived from the address.
    assign mem_rdata = mem_addr[7:0] ^ 8'hA5;

    bus_arbiter #(
        .N_REQ       (N_REQ),
        .WAIT_CYCLES (WAIT_CYCLES),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_r     (mem_r),
        .mem_w     (mem_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
`ifdef BUS_ARB_LOCK_EN
        if (lock[model_last] && req[model_last]) return model_last;
`endif
        for (int i = 1; i <= N_REQ; i++) begin
            int c;
            c = (model_last + i) % N_REQ;
            if (req[c]) return c;
        end
        return 0;
    endfunction

    task automatic set_master(input int m, input logic w, input logic [15:0] a,
                              input logic [7:0] d);
        we[m]                        = w;
        addr[m*ADDR_W +: ADDR_W]     = a;
        wdata[m*DATA_W +: DATA_W]    = d;
        req[m]                       = 1'b1;
    endtask

    // Called from the negedge of an IDLE cycle; returns at the negedge of the next IDLE cycle.
    task automatic do_access(input int exp_own, input bit keep, output time t_ack);
        txn_t             t;
        txn_t             got;
        logic [N_REQ-1:0] oh;
        oh          = '0;
        oh[exp_own] = 1'b1;
        t.own   = exp_own;
        t.is_wr = we[exp_own];
        t.a     = addr[exp_own*ADDR_W +: ADDR_W];
        t.d     = wdata[exp_own*DATA_W +: DATA_W];
        t.rd    = t.is_wr ? model_rdata : (t.a[7:0] ^ 8'hA5);
        sb.push_back(t);
        @(posedge clk);
        for (int c = 0; c <= WAIT_CYCLES; c++) begin
            @(negedge clk);
            check("gnt", 32'(gnt), 32'(oh));
            check("mem_r", 32'(mem_r), 32'(!t.is_wr));
            check("mem_w", 32'(mem_w), 32'(t.is_wr));
            check("mem_addr", 32'(mem_addr), 32'(t.a));
            check("ack_early", 32'(ack), 32'd0);
            check("busy", 32'(busy), 32'd1);
            if (t.is_wr) check("mem_wdata", 32'(mem_wdata), 32'(t.d));
        end
        @(negedge clk);
        got = sb.pop_front();
        check("ack", 32'(ack), 32'(oh));
        check("gnt_done", 32'(gnt), 32'(oh));
        check("strobes_done", 32'({mem_r, mem_w}), 32'd0);
        check("rdata", 32'(rdata), 32'(got.rd));
        model_rdata = got.rd;
        model_last  = got.own;
        t_ack       = $time;
        if (!keep) req[exp_own] = 1'b0;
        @(negedge clk);
        check("ack_clr", 32'(ack), 32'd0);
        check("gnt_clr", 32'(gnt), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        time t_prev, t_cur;
        int  exp_seq[4];
        reset = 1'b1;
        req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        model_last  = N_REQ - 1;
        model_rdata = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_strobes", 32'({mem_r, mem_w}), 32'd0);
        reset = 1'b0;

        // Master 0 reads 0x2000, memory returns 0xA5.
        set_master(0, 1'b0, 16'h2000, 8'h00);
        do_access(pick(), 1'b0, t_cur);
        check("rd_a5", 32'(rdata), 32'hA5);

        // Master 1 writes 0x3C to 0x8001; rdata must keep 0xA5.
        set_master(1, 1'b1, 16'h8001, 8'h3C);
        do_access(pick(), 1'b0, t_cur);
        check("wr_rdata_kept", 32'(rdata), 32'hA5);

        // Master 2 write puts the pointer on 2 so the rotation below starts at 0.
        set_master(2, 1'b1, 16'h0010, 8'h77);
        do_access(pick(), 1'b0, t_cur);

        // All three requesting continuously: 0,1,2,0,1,2 at 4 cycles each.
        set_master(0, 1'b0, 16'h1111, 8'h00);
        set_master(1, 1'b1, 16'h2222, 8'h5E);
        set_master(2, 1'b0, 16'h3333, 8'h00);
        t_prev = 0;
        for (int i = 0; i < 6; i++) begin
            do_access(i % 3, 1'b1, t_cur);
            if (i > 0) check("period", 32'(t_cur - t_prev), 32'd40);
            t_prev = t_cur;
        end
        req = '0;

        // Reset during master 2's access aborts it without an ack.
        set_master(2, 1'b0, 16'h4444, 8'h00);
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_mem_r", 32'(mem_r), 32'd1);
        check("pre_rst_gnt", 32'(gnt), 32'b100);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_strobes", 32'({mem_r, mem_w}), 32'd0);
        check("rst_mid_gnt", 32'(gnt), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_ack", 32'(ack), 32'd0);
        end
        reset       = 1'b0;
        model_last  = N_REQ - 1;
        model_rdata = 8'h00;
        set_master(0, 1'b0, 16'h2000, 8'h00);
        do_access(0, 1'b0, t_cur);
        req = '0;

        // Master 1 locked and holding, master 0 also requesting; lock dropped before the 4th.
`ifdef BUS_ARB_LOCK_EN
        exp_seq = '{1, 1, 1, 0};
`else
        exp_seq = '{1, 0, 1, 0};
`endif
        set_master(1, 1'b0, 16'h4001, 8'h00);
        set_master(0, 1'b0, 16'h0100, 8'h00);
        lock[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) lock[1] = 1'b0;
            do_access(exp_seq[i], 1'b1, t_cur);
        end
        req = '0;
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shares the single 16-bit-address / 8-bit-data memory bus between up to N_REQ masters (CPU fetch/execute, DMA, video refresh). Each master issues one byte access per request through a req/ack handshake; the arbiter picks a winner round-robin, drives the memory strobes for a fixed number of wait states, and returns read data with a one-cycle ack. It sits between the masters and the memory/IO decoder, replacing direct CPU ownership of the address bus and r/w strobes.

## Interface
- N_REQ, 3, number of masters (2..8); index 0 is the CPU.
- WAIT_CYCLES, 1, extra cycles mem_r/mem_w are held after the first access cycle (0..15).
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req  in  N_REQ  per-master request level; held until that master's ack.
- we  in  N_REQ  per-master write enable (1 = write, 0 = read); stable while req.
- lock  in  N_REQ  per-master bus lock (see Configuration).
- addr  in  N_REQ*ADDR_W  flattened addresses, master i at [i*ADDR_W +: ADDR_W].
- wdata  in  N_REQ*DATA_W  flattened write data, same packing.
- gnt  out  N_REQ  one-hot owner, high from ACCESS through DONE.
- ack  out  N_REQ  one-cycle completion pulse to the owner.
- rdata  out  DATA_W  read data, valid while ack high, held until next DONE.
- busy  out  1  high in any state other than IDLE.
- mem_addr  out  ADDR_W  registered address to memory.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_r  out  1  read strobe.
- mem_w  out  1  write strobe.

## Operation
- States: IDLE, ACCESS, DONE. Counter wcnt (4 bits), owner index own, round-robin pointer last.
- IDLE: if req == 0 stay. Else choose winner = first set bit of req scanning last+1, last+2, … modulo N_REQ. Register own = winner, gnt = onehot(winner), mem_addr/mem_wdata from winner's slice, mem_r = ~we[winner], mem_w = we[winner], wcnt = WAIT_CYCLES; go ACCESS.
- ACCESS: strobes and address held. If wcnt != 0, decrement; else capture rdata = mem_rdata (reads only; writes leave rdata unchanged), drop mem_r/mem_w, ack[own] = 1, last = own; go DONE.
- DONE: ack[own] high for exactly this cycle, gnt still high; next edge clears ack and gnt, go IDLE.
- Masters must hold req/we/addr/wdata stable from assertion until ack; a master still requesting in IDLE after its ack is treated as a new request.
- Requests arriving mid-access are only evaluated in IDLE; no preemption.
- mem_r and mem_w are never high together; both low outside ACCESS.

## Timing
- Reset values: state IDLE, gnt 0, ack 0, rdata 0, busy 0, mem_addr 0, mem_wdata 0, mem_r 0, mem_w 0, wcnt 0, last = N_REQ-1 (master 0 wins first arbitration).
- Reset mid-access: strobes drop asynchronously, access abandoned, no ack issued.
- Latency: req sampled in IDLE at edge k; strobes high during cycles k+1 … k+1+WAIT_CYCLES; ack high during cycle k+2+WAIT_CYCLES. Access period = WAIT_CYCLES+3 cycles including IDLE.
- Back-to-back fairness: with all masters requesting continuously, grants rotate 0,1,2,0,… with no master granted twice in a row.
- req deasserted before grant: ignored; the arbiter does not latch a request it has not selected.
- Undefined req bits above N_REQ do not exist; N_REQ=1 degenerates to a fixed owner.

## Configuration
- BUS_ARB_LOCK_EN defined: in IDLE, if lock[last] and req[last] are both high, last is regranted unconditionally, bypassing rotation (atomic read-modify-write sequences, DMA bursts). Lock is sampled only in IDLE.
- BUS_ARB_LOCK_EN undefined: lock port exists but is ignored; pure round-robin.

## Test plan
- Reset, then master 0 reads 0x2000 with mem_rdata = 0xA5, WAIT_CYCLES=1 -> mem_r high 2 cycles, ack[0] pulse 3 cycles after sample, rdata = 0xA5.
- Master 1 writes 0x3C to 0x8001 -> mem_w high with mem_addr 0x8001, mem_wdata 0x3C, mem_r stays 0, rdata unchanged.
- req = 3'b111 held, each re-asserted after ack -> gnt sequence 0,1,2,0,1,2; every access exactly 4 cycles.
- Assert reset during ACCESS of master 2 -> mem_r/mem_w/gnt drop same cycle, no ack[2]; after release master 0 wins first.
- BUS_ARB_LOCK_EN defined, master 1 with lock=1 and req held, master 0 requesting -> three consecutive grants to 1; drop lock -> next grant to 0.
- Same stimulus without BUS_ARB_LOCK_EN -> grants alternate 1,0,1.
